alu_seq_unit: RTL and testbench

ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_serial_shift.sv | 65 ++++++
 rtl/alu_seq_unit.sv | 139 +++++++++++++
 tb/tb_alu_seq_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes and datapath width, common to the
// ALU controller and the sequential ALU unit.
package alu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int SHAMT_W    = 5;

    typedef enum logic [3:0] {
        ALU_AND     = 4'b0000,
        ALU_OR      = 4'b0001,
        ALU_ADD     = 4'b0010,
        ALU_XOR     = 4'b0011,
        ALU_SLL     = 4'b0100,
        ALU_SRL     = 4'b0101,
        ALU_SUB     = 4'b0110,
        ALU_SRA     = 4'b0111,
        ALU_EQ      = 4'b1000,
        ALU_NE      = 4'b1001,
        ALU_GE      = 4'b1010,
        ALU_SLT     = 4'b1100,
        ALU_ADD_ALT = 4'b1101,
        ALU_SLT_ALT = 4'b1110
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } seq_state_e;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_serial_shift.sv
// Iterative one-bit-per-cycle shifter: loaded with a value and amount, it
// shifts once per enabled step until the remaining count reaches zero.
module alu_serial_shift
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic                 dir_right,
    input  logic                 arith,
    input  logic [DATA_W-1:0]    load_val,
    input  logic [SHAMT_W-1:0]   load_amt,
    output logic [DATA_W-1:0]    value,
    output logic                 done
);

    logic [DATA_W-1:0]  val_q, val_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               right_q, right_d;
    logic               arith_q, arith_d;
    logic               fill;

    assign fill  = arith_q & val_q[DATA_W-1];
    assign value = val_q;
    // done is high once nothing remains, or on the edge the final bit shifts
    assign done  = (cnt_q == '0) || (step && (cnt_q == SHAMT_W'(1)));

    always_comb begin
        val_d   = val_q;
        cnt_d   = cnt_q;
        right_d = right_q;
        arith_d = arith_q;
        if (load) begin
            val_d   = load_val;
            cnt_d   = load_amt;
            right_d = dir_right;
            arith_d = arith;
        end else if (step && (cnt_q != '0)) begin
            cnt_d = cnt_q - SHAMT_W'(1);
            if (right_q) begin
                val_d = {fill, val_q[DATA_W-1:1]};
            end else begin
                val_d = {val_q[DATA_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            val_q   <= '0;
            cnt_q   <= '0;
            right_q <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            val_q   <= val_d;
            cnt_q   <= cnt_d;
            right_q <= right_d;
            arith_q <= arith_d;
        end
    end

endmodule

// File: rtl/alu_seq_unit.sv
// Sequential ALU with valid/ready handshakes: single-cycle ops finish one
// cycle after accept, shifts iterate one bit per cycle via alu_serial_shift.
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        Operation,
    input  logic [DATA_W-1:0] SrcA,
    input  logic [DATA_W-1:0] SrcB,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ALUResult,
    output logic              BrFlag
);

    seq_state_e        state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              brflag_q, brflag_d;

    logic              accept;
    logic              shift_load;
    logic              shift_done;
    logic [DATA_W-1:0] shift_val;
    logic [DATA_W-1:0] res_c;
    logic              br_c;
    logic signed [DATA_W-1:0] sa, sb;

    assign in_ready   = (state_q == ST_IDLE);
    assign accept     = in_valid && in_ready;
    assign shift_load = accept && is_shift_op(Operation);
    assign out_valid  = (state_q == ST_DONE);
    assign sa         = a_q;
    assign sb         = b_q;

    alu_serial_shift #(
        .DATA_W(DATA_W)
    ) u_shift (
        .clk       (clk),
        .reset     (reset),
        .load      (shift_load),
        .step      (state_q == ST_SHIFT),
        .dir_right (Operation != ALU_SLL),
        .arith     (Operation == ALU_SRA),
        .load_val  (SrcA),
        .load_amt  (SrcB[SHAMT_W-1:0]),
        .value     (shift_val),
        .done      (shift_done)
    );

    // Result logic works only from captured operands, never the live inputs
    always_comb begin
        res_c = '0;
        br_c  = 1'b0;
        case (op_q)
            ALU_AND:                  res_c = a_q & b_q;
            ALU_OR:                   res_c = a_q | b_q;
            ALU_XOR:                  res_c = a_q ^ b_q;
            ALU_ADD, ALU_ADD_ALT:     res_c = a_q + b_q;
            ALU_SUB:                  res_c = a_q - b_q;
            ALU_SLL, ALU_SRL, ALU_SRA: res_c = shift_val;
            ALU_EQ:                   br_c  = (a_q == b_q);
            ALU_NE:                   br_c  = (a_q != b_q);
            ALU_GE:                   br_c  = (sa >= sb);
            ALU_SLT, ALU_SLT_ALT:     res_c = {{(DATA_W-1){1'b0}}, (sa < sb)};
            default: begin
                res_c = '0;
                br_c  = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        brflag_d = brflag_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d = Operation;
                    a_d  = SrcA;
                    b_d  = SrcB;
                    // a zero shift amount completes like any single-cycle op
                    if (is_shift_op(Operation) && (SrcB[SHAMT_W-1:0] != '0)) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                if (shift_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d  = ST_IDLE;
                    result_d = res_c;
                    brflag_d = br_c;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            brflag_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            brflag_q <= brflag_d;
        end
    end

    // Outside DONE the outputs show the last result that was handed off
    assign ALUResult = (state_q == ST_DONE) ? res_c : result_q;
    assign BrFlag    = (state_q == ST_DONE) ? br_c  : brflag_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed testbench for alu_seq_unit: hand-computed vectors covering
// latency, shifts, compares, back-pressure and mid-operation reset.
module tb_alu_seq_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  Operation;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        BrFlag;

    int errors = 0;
    int checks = 0;

    alu_seq_unit #(.DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Operation (Operation),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUResult (ALUResult),
        .BrFlag    (BrFlag)
    );

    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic check1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
        end
    endtask

    // Present one operation at a negedge; it is accepted on the next posedge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        Operation = 4'hF;
        SrcA      = 32'hDEAD_BEEF;
        SrcB      = 32'h1234_5678;
    endtask

    // Counts cycles after accept until out_valid, bounded.
    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 100);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat,
                          input logic [31:0] exp_res, input logic exp_br);
        int lat;
        issue(op, a, b);
        wait_valid(lat);
        check32({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check32({tag, "_result"}, ALUResult, exp_res);
        check1({tag, "_brflag"}, BrFlag, exp_br);
        consume();
        check1({tag, "_idle_ready"}, in_ready, 1'b1);
        check1({tag, "_idle_valid"}, out_valid, 1'b0);
        check32({tag, "_held_result"}, ALUResult, exp_res);
    endtask

    initial begin
        int lat;
        int seen;
        logic [31:0] held;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        Operation = 4'h0;
        SrcA      = 32'h0;
        SrcB      = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check1("reset_in_ready", in_ready, 1'b1);
        check1("reset_out_valid", out_valid, 1'b0);
        check32("reset_result", ALUResult, 32'h0);
        check1("reset_brflag", BrFlag, 1'b0);

        run_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0002, 1, 32'h0000_0001, 1'b0);
        run_op("sra4",     4'b0111, 32'h8000_0000, 32'd4,         5, 32'hF800_0000, 1'b0);
        run_op("sll31",    4'b0100, 32'h0000_0001, 32'd31,       32, 32'h8000_0000, 1'b0);
        run_op("sll0",     4'b0100, 32'h0000_0001, 32'd0,         1, 32'h0000_0001, 1'b0);
        run_op("srl4",     4'b0101, 32'hF000_0000, 32'd4,         5, 32'h0F00_0000, 1'b0);
        run_op("sra_pos",  4'b0111, 32'h4000_0000, 32'h0000_0022, 3, 32'h1000_0000, 1'b0);
        run_op("ge_neg",   4'b1010, 32'hFFFF_FFFF, 32'h0000_0001, 1, 32'h0000_0000, 1'b0);
        run_op("ge_eq",    4'b1010, 32'h0000_0005, 32'h0000_0005, 1, 32'h0000_0000, 1'b1);
        run_op("eq",       4'b1000, 32'h0000_0005, 32'h0000_0005, 1, 32'h0000_0000, 1'b1);
        run_op("ne",       4'b1001, 32'h0000_0005, 32'h0000_0006, 1, 32'h0000_0000, 1'b1);
        run_op("slt",      4'b1100, 32'hFFFF_FFFF, 32'h0000_0001, 1, 32'h0000_0001, 1'b0);
        run_op("slt_alt",  4'b1110, 32'h0000_0001, 32'hFFFF_FFFF, 1, 32'h0000_0000, 1'b0);
        run_op("sub",      4'b0110, 32'h0000_0003, 32'h0000_0005, 1, 32'hFFFF_FFFE, 1'b0);
        run_op("xor",      4'b0011, 32'hFF00_FF00, 32'h0F0F_0F0F, 1, 32'hF00F_F00F, 1'b0);
        run_op("or",       4'b0001, 32'hFF00_0000, 32'h0000_00FF, 1, 32'hFF00_00FF, 1'b0);
        run_op("add_alt",  4'b1101, 32'h7FFF_FFFF, 32'h0000_0001, 1, 32'h8000_0000, 1'b0);
        run_op("undef_b",  4'b1011, 32'h0000_0005, 32'h0000_0005, 1, 32'h0000_0000, 1'b0);
        run_op("undef_f",  4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h0000_0000, 1'b0);

        // Back-pressure: result must hold while new requests are offered
        issue(4'b0000, 32'hFF00_FF00, 32'h0F0F_0F0F);
        wait_valid(lat);
        check32("bp_latency", 32'(lat), 32'd1);
        for (int i = 0; i < 10; i++) begin
            Operation = 4'b0010;
            SrcA      = 32'(i);
            SrcB      = 32'h1000;
            in_valid  = 1'b1;
            @(negedge clk);
            check1("bp_out_valid", out_valid, 1'b1);
            check1("bp_in_ready", in_ready, 1'b0);
            check32("bp_result", ALUResult, 32'h0F00_0F00);
        end
        in_valid = 1'b0;
        consume();
        check1("bp_release_ready", in_ready, 1'b1);
        check1("bp_release_valid", out_valid, 1'b0);
        check32("bp_release_result", ALUResult, 32'h0F00_0F00);

        // Reset during the third shift cycle of a 20-bit SRL
        issue(4'b0101, 32'hFFFF_0000, 32'd20);
        repeat (3) @(negedge clk);
        check1("rst_mid_busy", in_ready, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check1("rst_mid_out_valid", out_valid, 1'b0);
        check32("rst_mid_result", ALUResult, 32'h0);
        check1("rst_mid_brflag", BrFlag, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check1("rst_after_in_ready", in_ready, 1'b1);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check32("rst_no_stale_result", 32'(seen), 32'd0);
        held = ALUResult;
        check32("rst_result_cleared", held, 32'h0);

        run_op("post_rst_add", 4'b0010, 32'h0000_0010, 32'h0000_0020, 1, 32'h0000_0030, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
